// File: rtl/rv32i_pkg.sv
// ============================================================================
// Module   : rv32i_pkg
// Brief    : Shared types and constants for the rv32i_seg instruction fetch.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv32i_pkg;

  // Fetch sequencer states
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    DRAIN = 3'd3,
    HOLD  = 3'd4
  } fetch_state_t;

  // addi x0, x0, 0 -- shown to ID before the first real instruction
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  // Sequential fetch advances one 32-bit word
  localparam int unsigned PC_STEP = 4;

endpackage

`default_nettype wire

// File: rtl/fetch_buffer.sv
// ============================================================================
// Module   : fetch_buffer
// Brief    : One-entry {pc, instr} holding register between IMEM and ID.
//            Flush clears the valid bit only; pc/instr keep their last value.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_buffer
  import rv32i_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            write_i,
  input  logic            consume_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] instr_i,
  output logic            valid_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] instr_o
);

  logic            valid_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] instr_q;

  // Capture on write; flush wins over everything so a redirected entry is never seen
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= XLEN'(INSTR_NOP);
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (write_i) begin
      valid_q <= 1'b1;
      pc_q    <= pc_i;
      instr_q <= instr_i;
    end else if (consume_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign instr_o = instr_q;

endmodule

`default_nettype wire

// File: rtl/fetch_ctrl.sv
// ============================================================================
// Module   : fetch_ctrl
// Brief    : IF-stage fetch sequencer. Owns the PC, issues one outstanding
//            IMEM request at a time, buffers one instruction for ID and
//            handles EX redirects.
//            Optional feature macro: FETCH_MISALIGN_CHK_EN (reject redirects
//            to non-word-aligned targets and flag them on fetch_misalign).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_ctrl
  import rv32i_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            if_valid,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  input  logic            if_ready,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            fetch_misalign
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            imem_req_q;
  logic            redir_acc;
  logic [XLEN-1:0] redir_target;
  logic            buf_write;
  logic            buf_consume;

  // Low two bits never reach the PC: fetch is always word aligned
  assign redir_target = redirect_pc & ~XLEN'(3);

`ifdef FETCH_MISALIGN_CHK_EN
  logic redir_misalign;
  logic fetch_misalign_q;

  // A misaligned target is refused outright: no PC change, no flush
  assign redir_misalign = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign redir_acc      = redirect_valid && !redir_misalign;
  assign fetch_misalign = fetch_misalign_q;
`else
  assign redir_acc      = redirect_valid;
  assign fetch_misalign = 1'b0;
`endif

  // Next-state / next-PC; an accepted redirect overrides every other event
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    buf_write   = 1'b0;
    buf_consume = 1'b0;
    if (redir_acc) begin
      pc_d = redir_target;
      case (state_q)
        // A granted request or one still in flight leaves a response to swallow
        REQ:     state_d = imem_gnt ? DRAIN : REQ;
        WAIT:    state_d = imem_rvalid ? REQ : DRAIN;
        DRAIN:   state_d = imem_rvalid ? REQ : DRAIN;
        default: state_d = REQ;
      endcase
    end else begin
      case (state_q)
        IDLE: state_d = REQ;
        REQ: begin
          if (imem_gnt) state_d = WAIT;
        end
        WAIT: begin
          if (imem_rvalid) begin
            state_d   = HOLD;
            pc_d      = pc_q + XLEN'(PC_STEP);
            buf_write = 1'b1;
          end
        end
        HOLD: begin
          if (if_ready) begin
            state_d     = REQ;
            buf_consume = 1'b1;
          end
        end
        DRAIN: begin
          if (imem_rvalid) state_d = REQ;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM state, PC and registered request strobe
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      pc_q       <= RESET_VECTOR;
      imem_req_q <= 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
      fetch_misalign_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      imem_req_q <= (state_d == REQ);
`ifdef FETCH_MISALIGN_CHK_EN
      fetch_misalign_q <= redir_misalign;
`endif
    end
  end

  assign imem_req  = imem_req_q;
  assign imem_addr = pc_q;

  fetch_buffer #(
    .XLEN (XLEN)
  ) u_fetch_buffer (
    .clk       (clk),
    .reset     (reset),
    .write_i   (buf_write),
    .consume_i (buf_consume),
    .flush_i   (redir_acc),
    .pc_i      (pc_q),
    .instr_i   (imem_rdata),
    .valid_o   (if_valid),
    .pc_o      (if_pc),
    .instr_o   (if_instr)
  );

endmodule

`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
// ============================================================================
// Module   : tb_fetch_ctrl
// Brief    : Self-checking bench for fetch_ctrl: directed vector table plus a
//            randomized run against an instruction-stream reference model.
//            Honours FETCH_MISALIGN_CHK_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_ctrl;
  import rv32i_pkg::*;

  localparam int          XLEN = 32;
  localparam logic [31:0] RV   = 32'h0000_0000;
  localparam logic [31:0] NOP  = INSTR_NOP;
`ifdef FETCH_MISALIGN_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  localparam logic [31:0] A_MIS = CHK ? 32'h0000_0000 : 32'h0000_0100;
  localparam logic [31:0] TOP   = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_misalign;

  always #5 clk = ~clk;

  fetch_ctrl #(
    .XLEN         (XLEN),
    .RESET_VECTOR (RV)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_ready       (if_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_misalign (fetch_misalign)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        rst;
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic        rdy;
    logic        rd;
    logic [31:0] rpc;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_val;
    logic [31:0] e_pc;
    logic [31:0] e_ins;
    logic        e_mis;
  } vec_t;

  vec_t vecs[$];

  // IMEM contents: a fixed scramble of the address
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A3C_0013;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic add(input logic rst, input logic gnt, input logic rv, input logic [31:0] rdata,
                     input logic rdy, input logic rd, input logic [31:0] rpc,
                     input logic e_req, input logic [31:0] e_addr, input logic e_val,
                     input logic [31:0] e_pc, input logic [31:0] e_ins, input logic e_mis);
    vec_t v;
    v = '{rst, gnt, rv, rdata, rdy, rd, rpc, e_req, e_addr, e_val, e_pc, e_ins, e_mis};
    vecs.push_back(v);
  endtask

  // Random-phase model state
  logic        pend;
  logic        pend_stale;
  int          pend_cnt;
  logic [31:0] pend_addr;
  logic [31:0] exp_pc;
  logic [31:0] prev_addr;
  logic [31:0] tmp;
  logic        prev_rst, prev_acc, prev_mis, prev_hold;
  logic        rst_c, acc, mis;
  int          deliveries;

  initial begin
    reset = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    if_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;

    // rst gnt rv rdata             rdy rd rpc           req addr      val pc      instr                 mis
    add(1, 0, 0, 0,                 0, 0, 0,            0, RV,        0, 0,      NOP,                  0);
    add(1, 0, 0, 0,                 0, 0, 0,            0, RV,        0, 0,      NOP,                  0);
    add(0, 0, 0, 0,                 0, 0, 0,            1, 32'h0,     0, 0,      NOP,                  0);
    add(0, 1, 0, 0,                 0, 0, 0,            0, 32'h0,     0, 0,      NOP,                  0);
    add(0, 0, 1, mem_f(32'h0),      0, 0, 0,            0, 32'h4,     1, 32'h0,  mem_f(32'h0),         0);
    add(0, 0, 0, 0,                 1, 0, 0,            1, 32'h4,     0, 32'h0,  mem_f(32'h0),         0);
    add(0, 1, 0, 0,                 0, 0, 0,            0, 32'h4,     0, 32'h0,  mem_f(32'h0),         0);
    add(0, 0, 1, mem_f(32'h4),      0, 0, 0,            0, 32'h8,     1, 32'h4,  mem_f(32'h4),         0);
    for (int k = 0; k < 5; k++)
      add(0, 0, 0, 0,               0, 0, 0,            0, 32'h8,     1, 32'h4,  mem_f(32'h4),         0);
    add(0, 0, 0, 0,                 1, 0, 0,            1, 32'h8,     0, 32'h4,  mem_f(32'h4),         0);
    add(0, 1, 0, 0,                 0, 0, 0,            0, 32'h8,     0, 32'h4,  mem_f(32'h4),         0);
    add(0, 0, 1, mem_f(32'h8),      0, 0, 0,            0, 32'hC,     1, 32'h8,  mem_f(32'h8),         0);
    add(0, 0, 0, 0,                 1, 0, 0,            1, 32'hC,     0, 32'h8,  mem_f(32'h8),         0);
    add(0, 1, 0, 0,                 0, 0, 0,            0, 32'hC,     0, 32'h8,  mem_f(32'h8),         0);
    add(0, 0, 0, 0,                 0, 1, 32'h100,      0, 32'h100,   0, 32'h8,  mem_f(32'h8),         0);
    add(0, 0, 1, 32'hDEAD_BEEF,     0, 0, 0,            1, 32'h100,   0, 32'h8,  mem_f(32'h8),         0);
    add(0, 1, 0, 0,                 0, 0, 0,            0, 32'h100,   0, 32'h8,  mem_f(32'h8),         0);
    add(0, 0, 1, mem_f(32'h100),    0, 0, 0,            0, 32'h104,   1, 32'h100,mem_f(32'h100),       0);
    add(0, 0, 0, 0,                 1, 0, 0,            1, 32'h104,   0, 32'h100,mem_f(32'h100),       0);
    add(0, 1, 0, 0,                 0, 0, 0,            0, 32'h104,   0, 32'h100,mem_f(32'h100),       0);
    add(0, 0, 1, mem_f(32'h104),    0, 1, 32'h40,       1, 32'h40,    0, 32'h100,mem_f(32'h100),       0);
    add(0, 1, 0, 0,                 0, 0, 0,            0, 32'h40,    0, 32'h100,mem_f(32'h100),       0);
    add(0, 0, 1, mem_f(32'h40),     0, 0, 0,            0, 32'h44,    1, 32'h40, mem_f(32'h40),        0);
    add(0, 0, 0, 0,                 1, 1, 32'h80,       1, 32'h80,    0, 32'h40, mem_f(32'h40),        0);
    add(0, 1, 0, 0,                 0, 0, 0,            0, 32'h80,    0, 32'h40, mem_f(32'h40),        0);
    add(0, 0, 1, mem_f(32'h80),     0, 0, 0,            0, 32'h84,    1, 32'h80, mem_f(32'h80),        0);
    add(0, 0, 0, 0,                 0, 1, TOP,          1, TOP,       0, 32'h80, mem_f(32'h80),        0);
    add(0, 1, 0, 0,                 0, 0, 0,            0, TOP,       0, 32'h80, mem_f(32'h80),        0);
    add(0, 0, 1, mem_f(TOP),        0, 0, 0,            0, 32'h0,     1, TOP,    mem_f(TOP),           0);
    add(0, 0, 0, 0,                 1, 0, 0,            1, 32'h0,     0, TOP,    mem_f(TOP),           0);
    add(0, 0, 0, 0,                 0, 1, 32'h102,      1, A_MIS,     0, TOP,    mem_f(TOP),           CHK);
    add(0, 0, 0, 0,                 0, 0, 0,            1, A_MIS,     0, TOP,    mem_f(TOP),           0);
    add(0, 1, 0, 0,                 0, 0, 0,            0, A_MIS,     0, TOP,    mem_f(TOP),           0);
    add(1, 0, 0, 0,                 0, 0, 0,            0, RV,        0, 32'h0,  NOP,                  0);
    add(0, 0, 1, 32'hDEAD_BEEF,     0, 0, 0,            1, 32'h0,     0, 32'h0,  NOP,                  0);
    add(0, 0, 1, 32'hDEAD_BEEF,     0, 0, 0,            1, 32'h0,     0, 32'h0,  NOP,                  0);
    add(0, 1, 0, 0,                 0, 0, 0,            0, 32'h0,     0, 32'h0,  NOP,                  0);
    add(0, 0, 1, mem_f(32'h0),      0, 0, 0,            0, 32'h4,     1, 32'h0,  mem_f(32'h0),         0);
    add(0, 0, 0, 0,                 1, 0, 0,            1, 32'h4,     0, 32'h0,  mem_f(32'h0),         0);

    for (int i = 0; i < vecs.size(); i++) begin
      reset          = vecs[i].rst;
      imem_gnt       = vecs[i].gnt;
      imem_rvalid    = vecs[i].rv;
      imem_rdata     = vecs[i].rdata;
      if_ready       = vecs[i].rdy;
      redirect_valid = vecs[i].rd;
      redirect_pc    = vecs[i].rpc;
      @(posedge clk); #1;
      check($sformatf("vec%0d imem_req", i), 32'(imem_req), 32'(vecs[i].e_req));
      if (vecs[i].e_req)
        check($sformatf("vec%0d imem_addr", i), imem_addr, vecs[i].e_addr);
      check($sformatf("vec%0d if_valid", i), 32'(if_valid), 32'(vecs[i].e_val));
      check($sformatf("vec%0d if_pc", i), if_pc, vecs[i].e_pc);
      check($sformatf("vec%0d if_instr", i), if_instr, vecs[i].e_ins);
      check($sformatf("vec%0d fetch_misalign", i), 32'(fetch_misalign), 32'(vecs[i].e_mis));
    end

    // Randomized run: IMEM with random grant/latency, random stalls, redirects and resets
    pend = 1'b0; pend_stale = 1'b0; pend_cnt = 0; pend_addr = '0;
    exp_pc = RV; prev_addr = '0; deliveries = 0;
    prev_rst = 1'b0; prev_acc = 1'b0; prev_mis = 1'b0; prev_hold = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      rst_c          = (cyc < 2) || ($urandom_range(0, 299) == 0);
      reset          = rst_c;
      if_ready       = ($urandom_range(0, 9) < 7);
      redirect_valid = !rst_c && ($urandom_range(0, 24) == 0);
      tmp            = $urandom;
      case ($urandom_range(0, 5))
        0:       redirect_pc = TOP;
        1:       redirect_pc = tmp | 32'h1;
        2:       redirect_pc = (tmp & 32'hFFFF_FFFC) | 32'h2;
        default: redirect_pc = tmp & 32'h0000_0FFC;
      endcase
      imem_rvalid = pend && (pend_cnt == 0);
      imem_rdata  = imem_rvalid ? mem_f(pend_addr) : $urandom;
      imem_gnt    = imem_req && !pend && !rst_c && ($urandom_range(0, 3) != 0);
      acc = redirect_valid && (!CHK || (redirect_pc[1:0] == 2'b00));
      mis = CHK && redirect_valid && (redirect_pc[1:0] != 2'b00);

      if (prev_rst) begin
        check("rand reset imem_req", 32'(imem_req), 32'd0);
        check("rand reset if_valid", 32'(if_valid), 32'd0);
        check("rand reset if_instr", if_instr, NOP);
        check("rand reset if_pc", if_pc, 32'd0);
        check("rand reset imem_addr", imem_addr, RV);
      end
      if (prev_acc)
        check("rand flush if_valid", 32'(if_valid), 32'd0);
      check("rand req_with_valid", 32'(imem_req && if_valid), 32'd0);
      check("rand fetch_misalign", 32'(fetch_misalign), 32'(prev_mis));
      if (prev_hold) begin
        check("rand req_held", 32'(imem_req), 32'd1);
        check("rand addr_stable", imem_addr, prev_addr);
      end
      if (imem_req && !pend_stale)
        check("rand req_while_outstanding", 32'(pend), 32'd0);
      if (!rst_c && if_valid && if_ready && !acc) begin
        check("rand deliver if_pc", if_pc, exp_pc);
        check("rand deliver if_instr", if_instr, mem_f(if_pc));
        exp_pc = exp_pc + 32'd4;
        deliveries++;
      end
      if (!rst_c && imem_req && imem_gnt && !acc)
        check("rand fetch imem_addr", imem_addr, exp_pc);

      prev_hold = !rst_c && imem_req && !imem_gnt && !acc;
      prev_addr = imem_addr;
      prev_rst  = rst_c;
      prev_acc  = acc;
      prev_mis  = mis;
      if (rst_c) exp_pc = RV;
      else if (acc) exp_pc = redirect_pc & 32'hFFFF_FFFC;
      if (rst_c && pend) pend_stale = 1'b1;
      if (imem_rvalid) begin
        pend = 1'b0;
        pend_stale = 1'b0;
      end else if (pend) begin
        pend_cnt--;
      end
      if (imem_gnt) begin
        pend      = 1'b1;
        pend_cnt  = $urandom_range(0, 2);
        pend_addr = imem_addr;
      end
      @(posedge clk); #1;
    end
    check("rand progress deliveries>=100", 32'(deliveries >= 100), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
